// File: rtl/cpu_mem_responder_if.sv
// CPU fetch/data bus plus boot-load stream between the CPU side and the memory responder.
interface cpu_mem_responder_if #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH = 10
);
   logic [ADDR_WIDTH-1:0] programAddress;
   logic [DATA_WIDTH-1:0] programData;
   logic [ADDR_WIDTH-1:0] dataAddress;
   logic                  WE;
   logic [DATA_WIDTH-1:0] writeData;
   logic [DATA_WIDTH-1:0] readData;
   logic                  loadValid;
   logic [DATA_WIDTH-1:0] loadData;
   logic                  loadLast;
   logic                  loadReady;
   logic [ADDR_WIDTH:0]   loadCount;
   logic                  loadDone;
   logic                  cpuReset;

   modport master (
      output programAddress, dataAddress, WE, writeData, loadValid, loadData, loadLast,
      input  programData, readData, loadReady, loadCount, loadDone, cpuReset
   );

   modport slave (
      input  programAddress, dataAddress, WE, writeData, loadValid, loadData, loadLast,
      output programData, readData, loadReady, loadCount, loadDone, cpuReset
   );
endinterface

// File: rtl/cpu_mem_responder.sv
// Unified program/data memory for the CPU. It is boot-loaded from a stream while the CPU is
// held in reset, then serves zero-wait-state fetches, loads and stores.
module cpu_mem_responder #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH = 10
) (
   input logic                clk,
   input logic                reset,
   cpu_mem_responder_if.slave bus
);
   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
   localparam int unsigned CNT_W = ADDR_WIDTH + 1;

   typedef enum logic [1:0] {S_LOAD, S_RELEASE, S_RUN} state_t;

   state_t                state;
   state_t                state_nxt;
   logic [ADDR_WIDTH-1:0] load_addr;
   logic [CNT_W-1:0]      load_count;
   logic                  load_ready;
   logic                  load_done;
   logic                  cpu_reset;
   logic                  accept;
   logic                  at_top;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   assign accept = (state == S_LOAD) && bus.loadValid;
   assign at_top = (load_addr == ADDR_WIDTH'(DEPTH - 1));

   always_ff @(posedge clk) begin
      if (reset) state <= S_LOAD;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_LOAD:    if (accept && (bus.loadLast || at_top)) state_nxt = S_RELEASE;
         S_RELEASE: state_nxt = S_RUN;
         S_RUN:     state_nxt = S_RUN;
         default:   state_nxt = S_LOAD;
      endcase
   end

   // Handshake/status outputs decode straight from the state flop, so they change only on an edge.
   always_comb begin
      load_ready = 1'b0;
      load_done  = 1'b0;
      cpu_reset  = 1'b1;
      case (state)
         S_LOAD: load_ready = 1'b1;
         S_RUN: begin
            load_done = 1'b1;
            cpu_reset = 1'b0;
         end
         default: ;
      endcase
   end

   // Load pointer saturates at the top word; the count can still reach DEPTH.
   always_ff @(posedge clk) begin
      if (reset) begin
         load_addr  <= '0;
         load_count <= '0;
      end else if (accept) begin
         load_count <= load_count + CNT_W'(1);
         if (!at_top) load_addr <= load_addr + ADDR_WIDTH'(1);
      end
   end

   // Array contents survive reset; only boot words (LOAD) or CPU stores (RUN) write it.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (accept)                         mem[load_addr]       <= bus.loadData;
         else if ((state == S_RUN) && bus.WE) mem[bus.dataAddress] <= bus.writeData;
      end
   end

   assign bus.programData = (state == S_RUN) ? mem[bus.programAddress] : '0;
   assign bus.readData    = (state == S_RUN) ? mem[bus.dataAddress]    : '0;
   assign bus.loadReady   = load_ready;
   assign bus.loadDone    = load_done;
   assign bus.cpuReset    = cpu_reset;
   assign bus.loadCount   = load_count;
endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder: boot load, release timing, RUN reads/writes and reset cases.
module tb_cpu_mem_responder;
   logic clk = 1'b0;
   logic reset;
   int   vecs = 0;
   int   errs = 0;

   cpu_mem_responder_if #(.DATA_WIDTH(16), .ADDR_WIDTH(10)) bus ();

   cpu_mem_responder #(.DATA_WIDTH(16), .ADDR_WIDTH(10)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [15:0] d, input logic last);
      bus.loadValid = 1'b1;
      bus.loadData  = d;
      bus.loadLast  = last;
      tick();
      bus.loadValid = 1'b0;
      bus.loadLast  = 1'b0;
   endtask

   task automatic do_reset(input int cycles);
      reset = 1'b1;
      repeat (cycles) tick();
      reset = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [9:0] a, input logic [15:0] exp);
      bus.dataAddress = a;
      #1;
      chk(tag, 32'(bus.readData), 32'(exp));
   endtask

   initial begin
      reset              = 1'b1;
      bus.programAddress = '0;
      bus.dataAddress    = '0;
      bus.WE             = 1'b0;
      bus.writeData      = '0;
      bus.loadValid      = 1'b0;
      bus.loadData       = '0;
      bus.loadLast       = 1'b0;

      // 1: reset state
      do_reset(2);
      chk("rst_cpuReset",  32'(bus.cpuReset), 32'd1);
      chk("rst_loadReady", 32'(bus.loadReady), 32'd1);
      chk("rst_loadDone",  32'(bus.loadDone), 32'd0);
      chk("rst_loadCount", 32'(bus.loadCount), 32'd0);
      chk("rst_progData",  32'(bus.programData), 32'd0);
      chk("rst_readData",  32'(bus.readData), 32'd0);

      // 2: three-word boot with last, one RELEASE cycle, then RUN
      push(16'h1234, 1'b0);
      push(16'hA005, 1'b0);
      push(16'hF000, 1'b1);
      chk("rel_cpuReset",  32'(bus.cpuReset), 32'd1);
      chk("rel_loadReady", 32'(bus.loadReady), 32'd0);
      chk("rel_loadDone",  32'(bus.loadDone), 32'd0);
      chk("rel_loadCount", 32'(bus.loadCount), 32'd3);
      tick();
      chk("run_cpuReset", 32'(bus.cpuReset), 32'd0);
      chk("run_loadDone", 32'(bus.loadDone), 32'd1);
      bus.programAddress = 10'd1;
      #1;
      chk("run_prog1", 32'(bus.programData), 32'h0000A005);
      rd("run_data0", 10'd0, 16'h1234);
      rd("run_data2", 10'd2, 16'hF000);

      // 3: store, read-during-write shows old word, WE=0 leaves word alone
      bus.dataAddress = 10'h3FE;
      bus.WE          = 1'b1;
      bus.writeData   = 16'h0123;
      tick();
      bus.writeData      = 16'hBEEF;
      bus.programAddress = 10'h3FE;
      #1;
      chk("rdw_old_read", 32'(bus.readData), 32'h0123);
      chk("rdw_old_prog", 32'(bus.programData), 32'h0123);
      tick();
      bus.WE        = 1'b0;
      bus.writeData = 16'h1111;
      #1;
      chk("rdw_new_read", 32'(bus.readData), 32'hBEEF);
      tick();
      chk("we0_read", 32'(bus.readData), 32'hBEEF);
      chk("we0_prog", 32'(bus.programData), 32'hBEEF);

      // 4: full 1024-word load, auto-exit at top address
      do_reset(1);
      for (int i = 0; i < 1024; i++) push(16'(i), 1'b0);
      chk("full_loadCount", 32'(bus.loadCount), 32'd1024);
      chk("full_loadReady", 32'(bus.loadReady), 32'd0);
      tick();
      chk("full_loadDone",  32'(bus.loadDone), 32'd1);
      chk("full_loadReady2", 32'(bus.loadReady), 32'd0);
      rd("full_3ff", 10'h3FF, 16'h03FF);
      rd("full_200", 10'h200, 16'h0200);
      rd("full_3fe", 10'h3FE, 16'h03FE);

      // 5/6: reset mid-load restarts pointer; stores during LOAD are ignored
      do_reset(1);
      for (int i = 0; i < 5; i++) push(16'h5000 + 16'(i), 1'b0);
      chk("mid_count5", 32'(bus.loadCount), 32'd5);
      do_reset(1);
      chk("mid_count0", 32'(bus.loadCount), 32'd0);
      bus.WE          = 1'b1;
      bus.dataAddress = 10'd7;
      bus.writeData   = 16'hDEAD;
      #1;
      chk("load_readData0", 32'(bus.readData), 32'd0);
      push(16'h6000, 1'b0);
      push(16'h6001, 1'b1);
      bus.WE = 1'b0;
      tick();
      chk("re_loadCount", 32'(bus.loadCount), 32'd2);
      rd("re_mem0", 10'd0, 16'h6000);
      rd("re_mem1", 10'd1, 16'h6001);
      rd("re_mem2", 10'd2, 16'h5002);
      rd("re_mem4", 10'd4, 16'h5004);
      rd("re_mem5", 10'd5, 16'h0005);
      rd("ign_we_mem7", 10'd7, 16'h0007);

      bus.loadValid = 1'b1;
      bus.loadData  = 16'h7777;
      bus.loadLast  = 1'b1;
      repeat (3) tick();
      bus.loadValid = 1'b0;
      bus.loadLast  = 1'b0;
      chk("runval_count", 32'(bus.loadCount), 32'd2);
      chk("runval_ready", 32'(bus.loadReady), 32'd0);
      rd("runval_mem2", 10'd2, 16'h5002);
      rd("runval_mem0", 10'd0, 16'h6000);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
